// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
// Keeps the widths, the x0 index and the arbiter source encoding in one place.
package regfile_wb_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] r);
    logic [NREG-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Write-back bus: issue reservations, two producer handshakes, and the
// registered write port with its forwarding copy and scoreboard status.
interface regfile_wb_ctrl_if;
  import regfile_wb_ctrl_pkg::*;

  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            byp_valid;
  logic [AW-1:0]   byp_addr;
  logic [XLEN-1:0] byp_data;
  logic [NREG-1:0] busy;
  logic            err;

  modport slave (
    input  issue_valid, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output byp_valid, byp_addr, byp_data,
    output busy, err
  );

  modport master (
    output issue_valid, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  byp_valid, byp_addr, byp_data,
    input  busy, err
  );
endinterface

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin arbiter. Index 0 = SRC_ALU, index 1 = SRC_LSU.
// The pointer names the winner of the next conflict and only moves on conflicts.
module wb_rr_arb2
  import regfile_wb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] rdy_o,
  output logic [1:0] gnt_o
);
  src_e ptr_q, ptr_d;
  logic conflict;

  assign conflict = req_i[0] & req_i[1];

  // A lone requester is always ready; ready is also high when nobody asks.
  assign rdy_o[0] = ~req_i[1] | (ptr_q == SRC_ALU);
  assign rdy_o[1] = ~req_i[0] | (ptr_q == SRC_LSU);
  assign gnt_o    = req_i & rdy_o;

  always_comb begin
    ptr_d = ptr_q;
    if (conflict) ptr_d = (ptr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= SRC_ALU;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller: arbitrates ALU/LSU results onto the registered RF
// write port, tracks pending writes in a busy scoreboard, flags protocol errors.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  regfile_wb_ctrl_if.slave bus
);
  logic [1:0]      rdy, gnt;
  logic            acc;
  logic [AW-1:0]   acc_rd;
  logic [XLEN-1:0] acc_data;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  logic [NREG-1:0] clr_vec, set_vec;
  logic            issue_dup, orphan;

  wb_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({bus.lsu_valid, bus.alu_valid}),
    .rdy_o (rdy),
    .gnt_o (gnt)
  );

  assign bus.alu_ready = rdy[0];
  assign bus.lsu_ready = rdy[1];

  always_comb begin
    acc      = |gnt;
    acc_rd   = gnt[1] ? bus.lsu_rd   : bus.alu_rd;
    acc_data = gnt[1] ? bus.lsu_data : bus.alu_data;
  end

  // Results to x0 are consumed but never reach the write port.
  always_comb begin
    rf_we_d    = acc && (acc_rd != REG_ZERO);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = acc_rd;
      rf_wdata_d = acc_data;
    end
  end

  // The write presented this cycle commits at the coming edge; a same-edge
  // issue to that register re-reserves it, so set is applied after clear.
  always_comb begin
    clr_vec   = rf_we_q ? reg_onehot(rf_waddr_q) : '0;
    set_vec   = (bus.issue_valid && bus.issue_rd != REG_ZERO) ? reg_onehot(bus.issue_rd) : '0;
    busy_d    = ((busy_q & ~clr_vec) | set_vec) & ~reg_onehot(REG_ZERO);
    issue_dup = bus.issue_valid && (bus.issue_rd != REG_ZERO) &&
                busy_q[bus.issue_rd] && !clr_vec[bus.issue_rd];
    orphan    = rf_we_d && !busy_q[acc_rd];
    err_d     = err_q | issue_dup | orphan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.byp_valid = rf_we_q;
  assign bus.byp_addr  = rf_waddr_q;
  assign bus.byp_data  = rf_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
endmodule
